// File: rtl/apb_regbank_pkg.sv
// Shared types and helpers for the apb_regbank APB3 register bank.
package apb_regbank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  localparam int MIN_NUM_REGS    = 2;
  localparam int MAX_NUM_REGS    = 64;
  localparam int MAX_WAIT_STATES = 15;
  localparam int WAIT_CNT_W      = $clog2(MAX_WAIT_STATES + 1);

  // Number of byte-offset bits below the register index in a byte address.
  function automatic int addr_lsb(input int data_width);
    return (data_width == 8) ? 0 : (data_width == 16) ? 1 : 2;
  endfunction

  function automatic bit params_legal(input int data_width, input int num_regs,
                                      input int wait_states, input int ctrl_bits);
    return ((data_width == 8) || (data_width == 16) || (data_width == 32)) &&
           (num_regs >= MIN_NUM_REGS) && (num_regs <= MAX_NUM_REGS) &&
           (wait_states >= 0) && (wait_states <= MAX_WAIT_STATES) &&
           (ctrl_bits >= 1) && (ctrl_bits <= data_width);
  endfunction

endpackage

// File: rtl/apb_regbank_ctrl.sv
// APB3 protocol FSM for apb_regbank: wait-state counter, address decode and
// error flag. Produces the registered pready/pslverr, a write-commit strobe
// and the register index / error of the transfer in progress.
//
// state   | meaning
// IDLE    | no transfer; a setup cycle captures address, direction and data
// WAIT    | access phase, counting down inserted wait states
// RESP    | pready=1; a write commits on the edge that ends this cycle
module apb_regbank_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int NUM_REGS    = 8,
  parameter int WAIT_STATES = 0,
  parameter int IDX_W       = 3
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic                  wr_commit,
  output logic                  rd_load,
  output logic [IDX_W-1:0]      idx,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] wdata
);
  import apb_regbank_pkg::*;

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LSB   = addr_lsb(DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LOW_MASK  = ADDR_WIDTH'(BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] REG_LIMIT = ADDR_WIDTH'(NUM_REGS);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_STATES);

  state_e                  state, nxt;
  logic [WAIT_CNT_W-1:0]   cnt, cnt_nxt;
  logic                    capture;
  logic [ADDR_WIDTH-1:0]   word_addr;
  logic                    live_err;
  logic                    cap_write, cap_err;
  logic [IDX_W-1:0]        cap_idx;
  logic [DATA_WIDTH-1:0]   cap_wdata;
  logic                    cur_write;

  assign word_addr = paddr >> LSB;
  assign live_err  = ((paddr & LOW_MASK) != '0) || (word_addr >= REG_LIMIT);

  // In IDLE the transfer is described by the live bus (setup cycle); after
  // that by what was captured, so reads can be sampled on the way into RESP.
  assign cur_write = (state == ST_IDLE) ? pwrite : cap_write;
  assign err       = (state == ST_IDLE) ? live_err : cap_err;
  assign idx       = (state == ST_IDLE) ? word_addr[IDX_W-1:0] : cap_idx;
  assign wdata     = cap_wdata;

  assign wr_commit = (state == ST_RESP) && cap_write && !cap_err;
  assign rd_load   = (nxt == ST_RESP) && !cur_write;

  // Next-state and wait-counter logic.
  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    capture = 1'b0;
    case (state)
      ST_IDLE: begin
        if (psel && !penable) begin
          capture = 1'b1;
          cnt_nxt = WAIT_LOAD;
          nxt     = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!psel) begin
          nxt = ST_IDLE;
        end else if (penable) begin
          cnt_nxt = cnt - 1'b1;
          if (cnt == WAIT_CNT_W'(1)) nxt = ST_RESP;
        end
      end
      ST_RESP: nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Transfer capture on the setup cycle.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cap_write <= 1'b0;
      cap_err   <= 1'b0;
      cap_idx   <= '0;
      cap_wdata <= '0;
    end else if (capture) begin
      cap_write <= pwrite;
      cap_err   <= live_err;
      cap_idx   <= word_addr[IDX_W-1:0];
      cap_wdata <= pwdata;
    end
  end

  // Registered handshake outputs, high only for the RESP cycle.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      pready  <= 1'b0;
      pslverr <= 1'b0;
    end else begin
      pready  <= (nxt == ST_RESP);
      pslverr <= (nxt == ST_RESP) && err;
    end
  end

endmodule

// File: rtl/apb_regbank.sv
// Parametrised APB3 slave register bank. Register 0 is control (CTRL_BITS
// implemented), registers 1..NUM_REGS-1 are full width.
// Optional feature: APB_REGBANK_PSTRB_EN enables per-byte write strobes.
module apb_regbank #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int NUM_REGS    = 8,
  parameter int CTRL_BITS   = 4,
  parameter int WAIT_STATES = 0
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr
);
  import apb_regbank_pkg::*;

  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [DATA_WIDTH-1:0] CTRL_MASK =
    (CTRL_BITS >= DATA_WIDTH) ? {DATA_WIDTH{1'b1}}
                              : DATA_WIDTH'((64'd1 << CTRL_BITS) - 64'd1);

  if (!params_legal(DATA_WIDTH, NUM_REGS, WAIT_STATES, CTRL_BITS)) begin : g_bad_params
    $error("apb_regbank: illegal parameter combination");
  end

  logic                  wr_commit;
  logic                  rd_load;
  logic [IDX_W-1:0]      idx;
  logic                  err;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] lane_mask;
  logic [DATA_WIDTH-1:0] rd_regs [NUM_REGS];

  apb_regbank_ctrl #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .WAIT_STATES(WAIT_STATES),
    .IDX_W      (IDX_W)
  ) u_ctrl (
    .pclk     (pclk),
    .presetn  (presetn),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .pready   (pready),
    .pslverr  (pslverr),
    .wr_commit(wr_commit),
    .rd_load  (rd_load),
    .idx      (idx),
    .err      (err),
    .wdata    (wdata)
  );

`ifdef APB_REGBANK_PSTRB_EN
  // Expand byte strobes into a bit mask; the strobes are taken from the RESP
  // cycle, where the master must still hold them.
  always_comb begin
    lane_mask = '0;
    for (int b = 0; b < STRB_W; b++) begin
      lane_mask[b*8 +: 8] = {8{pstrb[b]}};
    end
  end
`else
  logic unused_pstrb;
  assign unused_pstrb = ^pstrb;
  assign lane_mask    = '1;
`endif

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    localparam logic [DATA_WIDTH-1:0] KEEP = (i == 0) ? CTRL_MASK : {DATA_WIDTH{1'b1}};
    logic [DATA_WIDTH-1:0] q;
    logic [DATA_WIDTH-1:0] wmask;
    assign wmask      = lane_mask & KEEP;
    assign rd_regs[i] = q;

    // Register storage: masked update when the committing write targets it.
    always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
        q <= '0;
      end else if (wr_commit && (idx == IDX_W'(i))) begin
        q <= (q & ~wmask) | (wdata & wmask);
      end
    end
  end

  // Read data is sampled on entry to RESP and forced to zero otherwise.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      prdata <= '0;
    end else if (rd_load && !err) begin
      prdata <= rd_regs[idx];
    end else begin
      prdata <= '0;
    end
  end

endmodule

// File: tb/tb_apb_regbank.sv
// Directed self-checking bench for apb_regbank: one instance with no wait
// states and one with three, sharing clock, reset and bus signals.
module tb_apb_regbank;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic        psel0 = 1'b0, psel3 = 1'b0;
  logic        penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic [3:0]  pstrb = 4'hF;
  logic [31:0] prdata0, prdata3;
  logic        pready0, pready3, pslverr0, pslverr3;

  int errors = 0;
  int checks = 0;

  always #5 pclk = ~pclk;

  apb_regbank #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_REGS(8), .CTRL_BITS(4), .WAIT_STATES(0)) u_dut0 (
    .pclk(pclk), .presetn(presetn), .psel(psel0), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata0), .pready(pready0), .pslverr(pslverr0));

  apb_regbank #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_REGS(8), .CTRL_BITS(4), .WAIT_STATES(3)) u_dut3 (
    .pclk(pclk), .presetn(presetn), .psel(psel3), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata3), .pready(pready3), .pslverr(pslverr3));

  // Bus driver: starts the setup cycle immediately (caller is just past a
  // rising edge) and returns just past the edge that completes the transfer.
  // acc is the access cycle in which pready was seen, -1 if it never came.
  task automatic apb_xfer(input bit use3, input bit wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] strb,
                          output logic [31:0] rdata, output logic err, output int acc);
    int n;
    psel0 = !use3; psel3 = use3; penable = 1'b0;
    pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
    @(posedge pclk); #1;
    penable = 1'b1;
    n = 1;
    while (((use3 ? pready3 : pready0) !== 1'b1) && n < 20) begin
      @(posedge pclk); #1;
      n++;
    end
    acc   = ((use3 ? pready3 : pready0) === 1'b1) ? n : -1;
    rdata = use3 ? prdata3 : prdata0;
    err   = use3 ? pslverr3 : pslverr0;
    @(posedge pclk); #1;
    psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic er; int acc;
    checks++;
    if ({pready0, pslverr0, prdata0, pready3, pslverr3, prdata3} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got r0=%b e0=%b d0=%h r3=%b e3=%b d3=%h required all 0",
               pready0, pslverr0, prdata0, pready3, pslverr3, prdata3);
    end
    #3 presetn = 1'b1;
    @(posedge pclk); #1;
    for (int i = 0; i < 8; i++) begin
      apb_xfer(1'b0, 1'b0, 32'(i * 4), 32'h0, 4'hF, rd, er, acc);
      checks++;
      if (rd !== 32'h0 || er !== 1'b0 || acc != 1) begin
        errors++;
        $display("FAIL reset_read reg%0d got data=%h err=%b acc=%0d required data=0 err=0 acc=1",
                 i, rd, er, acc);
      end
    end
  endtask

  task automatic test_ctrl_and_full();
    logic [31:0] rd; logic er; int acc;
    apb_xfer(1'b0, 1'b1, 32'h0, 32'hFFFF_FFFF, 4'hF, rd, er, acc);
    checks++;
    if (er !== 1'b0 || acc != 1) begin
      errors++; $display("FAIL ctrl_write got err=%b acc=%0d required err=0 acc=1", er, acc);
    end
    apb_xfer(1'b0, 1'b0, 32'h0, 32'h0, 4'hF, rd, er, acc);
    checks++;
    if (rd !== 32'h0000_000F || er !== 1'b0) begin
      errors++; $display("FAIL ctrl_read got data=%h err=%b required data=0000000f err=0", rd, er);
    end
    apb_xfer(1'b0, 1'b1, 32'h1C, 32'hA5A5_1234, 4'hF, rd, er, acc);
    apb_xfer(1'b0, 1'b0, 32'h1C, 32'h0, 4'hF, rd, er, acc);
    checks++;
    if (rd !== 32'hA5A5_1234 || er !== 1'b0 || acc != 1) begin
      errors++;
      $display("FAIL reg7_read got data=%h err=%b acc=%0d required data=a5a51234 err=0 acc=1", rd, er, acc);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int acc;
    apb_xfer(1'b0, 1'b1, 32'h4, 32'h0000_BEEF, 4'hF, rd, er, acc);
    apb_xfer(1'b0, 1'b0, 32'h4, 32'h0, 4'hF, rd, er, acc);
    checks++;
    if (rd !== 32'h0000_BEEF || acc != 1) begin
      errors++; $display("FAIL b2b_read got data=%h acc=%0d required data=0000beef acc=1", rd, acc);
    end
    checks++;
    if (pready0 !== 1'b0 || prdata0 !== 32'h0 || pslverr0 !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_read got rdy=%b data=%h err=%b required 0 0 0", pready0, prdata0, pslverr0);
    end
  endtask

  task automatic test_decode_err();
    logic [31:0] rd; logic er; int acc;
    logic [31:0] exp_regs [8];
    apb_xfer(1'b0, 1'b1, 32'h20, 32'h0000_DEAD, 4'hF, rd, er, acc);
    checks++;
    if (er !== 1'b1 || acc != 1) begin
      errors++; $display("FAIL err_write_oor got err=%b acc=%0d required err=1 acc=1", er, acc);
    end
    apb_xfer(1'b0, 1'b0, 32'h20, 32'h0, 4'hF, rd, er, acc);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL err_read_oor got err=%b data=%h required err=1 data=0", er, rd);
    end
    checks++;
    if (pslverr0 !== 1'b0) begin
      errors++; $display("FAIL pslverr_after got %b required 0", pslverr0);
    end
    apb_xfer(1'b0, 1'b1, 32'h6, 32'h0000_DEAD, 4'hF, rd, er, acc);
    checks++;
    if (er !== 1'b1) begin
      errors++; $display("FAIL err_write_misaligned got err=%b required 1", er);
    end
    apb_xfer(1'b0, 1'b0, 32'h6, 32'h0, 4'hF, rd, er, acc);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL err_read_misaligned got err=%b data=%h required err=1 data=0", er, rd);
    end
    exp_regs = '{32'h0000_000F, 32'h0000_BEEF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hA5A5_1234};
    for (int i = 0; i < 8; i++) begin
      apb_xfer(1'b0, 1'b0, 32'(i * 4), 32'h0, 4'hF, rd, er, acc);
      checks++;
      if (rd !== exp_regs[i] || er !== 1'b0) begin
        errors++;
        $display("FAIL err_no_change reg%0d got data=%h err=%b required data=%h err=0", i, rd, er, exp_regs[i]);
      end
    end
  endtask

  task automatic test_pstrb();
    logic [31:0] rd; logic er; int acc;
    logic [31:0] exp1, exp2;
`ifdef APB_REGBANK_PSTRB_EN
    exp1 = 32'h11BB_33DD;
    exp2 = 32'h11BB_33DD;
`else
    exp1 = 32'hAABB_CCDD;
    exp2 = 32'h0000_0000;
`endif
    apb_xfer(1'b0, 1'b1, 32'h8, 32'h1122_3344, 4'hF, rd, er, acc);
    apb_xfer(1'b0, 1'b1, 32'h8, 32'hAABB_CCDD, 4'b0101, rd, er, acc);
    apb_xfer(1'b0, 1'b0, 32'h8, 32'h0, 4'hF, rd, er, acc);
    checks++;
    if (rd !== exp1) begin
      errors++; $display("FAIL pstrb_partial got data=%h required %h", rd, exp1);
    end
    apb_xfer(1'b0, 1'b1, 32'h8, 32'h0, 4'b0000, rd, er, acc);
    checks++;
    if (er !== 1'b0) begin
      errors++; $display("FAIL pstrb_zero_err got err=%b required 0", er);
    end
    apb_xfer(1'b0, 1'b0, 32'h8, 32'h0, 4'hF, rd, er, acc);
    checks++;
    if (rd !== exp2) begin
      errors++; $display("FAIL pstrb_zero got data=%h required %h", rd, exp2);
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic er; int acc;
    apb_xfer(1'b1, 1'b1, 32'h4, 32'h0000_1234, 4'hF, rd, er, acc);
    checks++;
    if (acc != 4 || er !== 1'b0) begin
      errors++; $display("FAIL ws_write got acc=%0d err=%b required acc=4 err=0", acc, er);
    end
    apb_xfer(1'b1, 1'b0, 32'h4, 32'h0, 4'hF, rd, er, acc);
    checks++;
    if (acc != 4 || rd !== 32'h0000_1234) begin
      errors++; $display("FAIL ws_read got acc=%0d data=%h required acc=4 data=00001234", acc, rd);
    end
    // Abort: two access cycles of a write, then psel drops.
    psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h4; pwdata = 32'h55; pstrb = 4'hF;
    @(posedge pclk); #1 penable = 1'b1;
    @(posedge pclk); #1;
    @(posedge pclk); #1 psel3 = 1'b0; penable = 1'b0;
    repeat (6) begin
      @(posedge pclk); #1;
      checks++;
      if (pready3 !== 1'b0) begin
        errors++; $display("FAIL abort_pready got %b required 0", pready3);
      end
    end
    apb_xfer(1'b1, 1'b0, 32'h4, 32'h0, 4'hF, rd, er, acc);
    checks++;
    if (rd !== 32'h0000_1234 || acc != 4) begin
      errors++; $display("FAIL abort_no_write got data=%h acc=%0d required data=00001234 acc=4", rd, acc);
    end
    apb_xfer(1'b1, 1'b0, 32'h20, 32'h0, 4'hF, rd, er, acc);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0 || acc != 4) begin
      errors++; $display("FAIL ws_err got err=%b data=%h acc=%0d required err=1 data=0 acc=4", er, rd, acc);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int acc;
    psel0 = 1'b1; psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h8; pwdata = 32'h0000_DEAD; pstrb = 4'hF;
    @(posedge pclk); #1 penable = 1'b1;
    checks++;
    if (pready0 !== 1'b1 || pready3 !== 1'b0) begin
      errors++; $display("FAIL mid_pre got rdy0=%b rdy3=%b required 1 0", pready0, pready3);
    end
    #2 presetn = 1'b0;
    #1;
    checks++;
    if ({pready0, pslverr0, prdata0, pready3, pslverr3, prdata3} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs got r0=%b e0=%b d0=%h r3=%b e3=%b d3=%h required all 0",
               pready0, pslverr0, prdata0, pready3, pslverr3, prdata3);
    end
    psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
    @(negedge pclk) presetn = 1'b1;
    @(posedge pclk); #1;
    apb_xfer(1'b1, 1'b0, 32'h8, 32'h0, 4'hF, rd, er, acc);
    checks++;
    if (rd !== 32'h0 || acc != 4) begin
      errors++; $display("FAIL mid_lost_write3 got data=%h acc=%0d required data=0 acc=4", rd, acc);
    end
    apb_xfer(1'b1, 1'b0, 32'h4, 32'h0, 4'hF, rd, er, acc);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL mid_cleared3 got data=%h required 0", rd);
    end
    apb_xfer(1'b0, 1'b0, 32'h8, 32'h0, 4'hF, rd, er, acc);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL mid_lost_write0 got data=%h required 0", rd);
    end
    apb_xfer(1'b0, 1'b0, 32'h0, 32'h0, 4'hF, rd, er, acc);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL mid_cleared_ctrl got data=%h required 0", rd);
    end
    apb_xfer(1'b0, 1'b0, 32'h1C, 32'h0, 4'hF, rd, er, acc);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL mid_cleared_reg7 got data=%h required 0", rd);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_ctrl_and_full();
    test_back_to_back();
    test_decode_err();
    test_pstrb();
    test_wait_states();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_regbank.md
# apb_regbank

Parametrised APB3 slave register bank: the next generation of our fixed four-register APB slave. Register count, data width and access latency are generic, and the protocol handshake is complete, with `pready`, `pslverr`, programmable wait states and transfer abort. It sits behind the APB interconnect and serves as the control/status store for peripheral blocks and as the standard DUT for our RAL benches.

## Interface
Parameters:
- `DATA_WIDTH`, 32: register and bus data width; must be 8, 16 or 32.
- `ADDR_WIDTH`, 32: `paddr` width.
- `NUM_REGS`, 8: number of registers, 2..64.
- `CTRL_BITS`, 4: implemented bits of register 0 (control); upper bits read 0.
- `WAIT_STATES`, 0: extra access cycles inserted before `pready`, 0..15.

Ports:
- `pclk`, input, 1: clock, rising edge.
- `presetn`, input, 1: asynchronous active-low reset.
- `psel`, input, 1: slave select.
- `penable`, input, 1: access phase.
- `pwrite`, input, 1: 1 = write, 0 = read.
- `paddr`, input, `ADDR_WIDTH`: byte address.
- `pwdata`, input, `DATA_WIDTH`: write data.
- `pstrb`, input, `DATA_WIDTH/8`: byte strobes; used only with the macro in Configuration.
- `prdata`, output, `DATA_WIDTH`: read data.
- `pready`, output, 1: transfer complete.
- `pslverr`, output, 1: transfer error.

## Operation
- Register *i* is at byte address *i*·(`DATA_WIDTH`/8).
- Register 0 is control: only bits [`CTRL_BITS`-1:0] are stored.
- Registers 1..`NUM_REGS`-1 are full-width read/write.
- A decode error occurs when the address is misaligned (low bits ≠ 0) or at or above `NUM_REGS`·(`DATA_WIDTH`/8).
  - Error write: no register changes.
  - Error read: `prdata` = 0.
  - Either way, `pslverr` = 1 in the `pready` cycle.
- FSM states and transitions:
  - IDLE: on a setup cycle (`psel`=1, `penable`=0), capture `paddr`, `pwrite` and `pwdata`. Go to RESP if `WAIT_STATES`=0; otherwise go to WAIT and load the counter with `WAIT_STATES`.
  - WAIT: on each access cycle (`psel`=`penable`=1), decrement the counter; on the cycle it reaches 1, go to RESP. If `psel`=0, abort: go to IDLE with no write.
  - RESP: `pready`=1. A write commits on the rising edge that ends this cycle. Next state is IDLE.
- Reads sample register contents on entry to RESP.
- Writes use the captured address and data. The master's signals in the RESP cycle must match them (APB rule); this is not checked.
- `penable`=1 while in IDLE: ignored (protocol violation, no effect).
- Reset values: all registers 0, state IDLE, `prdata` 0, `pready` 0, `pslverr` 0.
- Reset asserted mid-transfer: immediate return to IDLE and all registers cleared; a pending write is lost.

## Timing
- `pready`, `pslverr` and `prdata` are registered.
- Access phase length is `WAIT_STATES`+1 cycles.
- The transfer completes on the edge after `pready` rises.
- `prdata` and `pslverr` are nonzero only while `pready`=1; they are 0 in every other cycle.
- A write is visible to a read whose setup cycle immediately follows the write's RESP cycle.
- Back-to-back transfers: a new setup cycle in the cycle after RESP is accepted from IDLE, with no dead cycle.

## Configuration
- `APB_REGBANK_PSTRB_EN` defined: a write updates only byte lanes whose `pstrb` bit is 1. `pstrb`=0 on all lanes is a legal no-op write with `pslverr`=0.
- Macro undefined: `pstrb` is ignored and every write updates all bytes.
- Reads are identical in both builds.

## Structure
- Package `apb_regbank_pkg` holds:
  - the state enum (IDLE, WAIT, RESP);
  - the byte-lane/address-to-index helper function;
  - parameter legality constants.
- Sub-module `apb_regbank_ctrl` holds the protocol FSM, wait counter and address decode/error flag. It outputs a write-commit strobe, a register index and an error flag.
- Top level holds register storage, strobe masking and the read mux.

## Test plan
- Reset, then read all registers (`DATA_WIDTH`=32, `NUM_REGS`=8): every read returns 0 with `pslverr`=0, and `pready` asserts in the first access cycle.
- Write 0xFFFF_FFFF to 0x0, then read 0x0: returns 0x0000_000F. Write 0xA5A5_1234 to 0x1C, then read 0x1C: returns 0xA5A5_1234.
- `WAIT_STATES`=3: `pready` rises on the 4th access cycle. Drop `psel` after 2 access cycles of a write of 0x55 to 0x4: register 1 is unchanged.
- Access 0x20 and then 0x6: `pslverr`=1 and `prdata`=0 for both, and no register changes.
- With `APB_REGBANK_PSTRB_EN`: write 0x1122_3344 to 0x8, then 0xAABB_CCDD with `pstrb`=4'b0101; a read returns 0x11BB_33DD.
- Assert `presetn` low during the WAIT state of a write: all outputs go to 0 immediately, and a later read returns 0.
